// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream packet buffer.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
package axis_pkg;

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_DROP = 1'b1
  } ingress_state_t;

  function automatic int buf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Packet storage array: one write port, one combinational read port.
// Read data follows raddr in the same cycle; a write shows up after the edge.
module axis_buf_ram
  import axis_pkg::*;
#(
  parameter int WIDTH      = 37,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = buf_depth(ADDR_WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_buffer.sv
// Store-and-forward AXI-Stream packet FIFO; overflowing packets are dropped whole and counted.
// First beat is valid one cycle after tlast commits; ingress is stalled only by s_axis_enable.
module axis_packet_buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic                      s_axis_enable,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic                      m_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ADDR_WIDTH:0]       pkt_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int WW    = DATA_WIDTH + KW + 1;
  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = buf_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);

  ingress_state_t state, state_nxt;

  logic [PW-1:0] wr_cur, wr_commit, rd_ptr;
  logic [PW-1:0] wr_cur_nxt, wr_commit_nxt;
  logic          mem_we, commit_evt, drop_evt;
  logic          accept, full, load, rd_last;
  logic [WW-1:0] rd_word;

  assign s_axis_tready = s_axis_enable;
  assign accept        = s_axis_tvalid && s_axis_enable;
  assign full          = (wr_cur - rd_ptr) == DEPTH_PTR;

  axis_buf_ram #(
    .WIDTH      (WW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (mem_we),
    .waddr (wr_cur[ADDR_WIDTH-1:0]),
    .wdata ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_word)
  );

  assign rd_last = rd_word[WW-1];

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) state <= ST_RECV;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RECV: if (accept && full && !s_axis_tlast) state_nxt = ST_DROP;
      ST_DROP: if (accept && s_axis_tlast)          state_nxt = ST_RECV;
      default: state_nxt = ST_RECV;
    endcase
  end

  // A full buffer rewinds the speculative pointer so the partial packet vanishes.
  always_comb begin
    mem_we        = 1'b0;
    commit_evt    = 1'b0;
    drop_evt      = 1'b0;
    wr_cur_nxt    = wr_cur;
    wr_commit_nxt = wr_commit;
    unique case (state)
      ST_RECV: begin
        if (accept && !full) begin
          mem_we     = 1'b1;
          wr_cur_nxt = wr_cur + 1'b1;
          if (s_axis_tlast) begin
            wr_commit_nxt = wr_cur + 1'b1;
            commit_evt    = 1'b1;
          end
        end else if (accept) begin
          wr_cur_nxt = wr_commit;
          drop_evt   = s_axis_tlast;
        end
      end
      ST_DROP: drop_evt = accept && s_axis_tlast;
      default: ;
    endcase
  end

  assign load = (pkt_count != '0) && (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      wr_cur        <= '0;
      wr_commit     <= '0;
      rd_ptr        <= '0;
      pkt_count     <= '0;
      drop_count    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
    end else begin
      wr_cur    <= wr_cur_nxt;
      wr_commit <= wr_commit_nxt;

      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rd_word[DATA_WIDTH-1:0];
        m_axis_tstrb  <= rd_word[DATA_WIDTH +: KW];
        m_axis_tlast  <= rd_last;
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      unique case ({commit_evt, load && rd_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase

      if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench for axis_packet_buffer at DATA_WIDTH=32, ADDR_WIDTH=4 (16-word array).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_axis_packet_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid, s_tlast, s_tready;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid, m_tlast;
  logic [4:0]  pkt_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_dat[$];
  logic        got_last[$];
  logic [3:0]  got_strb[$];

  always #5 clk = ~clk;

  axis_packet_buffer #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (4),
    .DROP_CNT_WIDTH (16)
  ) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_enable (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  task automatic send_beat(input logic [31:0] d, input logic last);
    en       = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = 4'hF;
    s_tlast  = last;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Drains up to n beats with m_tready held high, giving up after max_cyc cycles.
  task automatic collect(input int n, input int max_cyc, output int cyc_used);
    int cyc = 0;
    got_dat.delete(); got_last.delete(); got_strb.delete();
    m_tready = 1'b1;
    while (got_dat.size() < n && cyc < max_cyc) begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        got_dat.push_back(m_tdata);
        got_last.push_back(m_tlast);
        got_strb.push_back(m_tstrb);
      end
      @(posedge clk); #1;
      cyc++;
    end
    cyc_used = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_en1: got %b expected 1", s_tready); end
    en = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_en0: got %b expected 0", s_tready); end
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0 || m_tstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b data=%h strb=%h expected all 0", m_tvalid, m_tlast, m_tdata, m_tstrb);
    end
    checks++;
    if (pkt_count !== 5'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got pkt=%0d drop=%0d expected 0/0", pkt_count, drop_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [31:0] exp_d[4];
    int cyc;
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(exp_d[i], i == 3);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL single_commit_edge: got valid=%b pkt=%0d expected valid=0 pkt=1", m_tvalid, pkt_count);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h11 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got valid=%b data=%h last=%b expected 1/11/0", m_tvalid, m_tdata, m_tlast);
    end
    @(posedge clk); #1;
    collect(4, 20, cyc);
    checks++;
    if (got_dat.size() != 4 || cyc != 4) begin
      errors++;
      $display("FAIL single_count: got %0d beats in %0d cycles expected 4 in 4", got_dat.size(), cyc);
    end
    for (int i = 0; i < got_dat.size() && i < 4; i++) begin
      checks++;
      if (got_dat[i] !== exp_d[i] || got_last[i] !== (i == 3) || got_strb[i] !== 4'hF) begin
        errors++;
        $display("FAIL single_beat%0d: got data=%h last=%b strb=%h expected %h/%b/F", i, got_dat[i], got_last[i], got_strb[i], exp_d[i], i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL single_drained: got valid=%b pkt=%0d expected 0/0", m_tvalid, pkt_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_tlast();
    int seen = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(32'hC0 + i, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_tvalid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL no_tlast_hold: got valid cycles=%0d pkt=%0d expected 0/0", seen, pkt_count);
    end
    do_reset();
  endtask

  task automatic test_overflow_drop();
    int cyc;
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(32'hA0 + i, i == 9);
    for (int i = 0; i < 10; i++) send_beat(32'hB0 + i, i == 9);
    @(negedge clk);
    checks++;
    if (drop_count !== 16'd1 || pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL overflow_counters: got drop=%0d pkt=%0d expected 1/1", drop_count, pkt_count);
    end
    @(posedge clk); #1;
    collect(11, 40, cyc);
    checks++;
    if (got_dat.size() != 10) begin
      errors++;
      $display("FAIL overflow_count: got %0d beats expected 10", got_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < 10; i++) begin
      checks++;
      if (got_dat[i] !== 32'hA0 + i || got_last[i] !== (i == 9)) begin
        errors++;
        $display("FAIL overflow_beat%0d: got %h last=%b expected %h last=%b", i, got_dat[i], got_last[i], 32'hA0 + i, i == 9);
      end
    end
    do_reset();
  endtask

  task automatic test_oversize();
    int cyc;
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(32'hD0 + i, i == 19);
    send_beat(32'hAA, 1'b0);
    send_beat(32'hBB, 1'b1);
    @(negedge clk);
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL oversize_drop: got %0d expected 1", drop_count);
    end
    @(posedge clk); #1;
    collect(3, 20, cyc);
    checks++;
    if (got_dat.size() != 2) begin
      errors++;
      $display("FAIL oversize_count: got %0d beats expected 2", got_dat.size());
    end else begin
      checks++;
      if (got_dat[0] !== 32'hAA || got_last[0] !== 1'b0 || got_dat[1] !== 32'hBB || got_last[1] !== 1'b1) begin
        errors++;
        $display("FAIL oversize_data: got %h/%b %h/%b expected AA/0 BB/1", got_dat[0], got_last[0], got_dat[1], got_last[1]);
      end
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[6];
    logic        exp_l[6];
    exp_d = '{32'h61, 32'h62, 32'h63, 32'h71, 32'h72, 32'h73};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    got_dat.delete(); got_last.delete(); got_strb.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(exp_d[i], exp_l[i]);
      end
      begin : rx
        int          cyc;
        logic        stalled;
        logic [31:0] pd;
        logic        pl;
        cyc = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
        while (got_dat.size() < 6 && cyc < 60) begin
          m_tready = (cyc % 2 == 0);
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
              errors++;
              $display("FAIL b2b_stall_hold: got valid=%b data=%h last=%b expected 1/%h/%b", m_tvalid, m_tdata, m_tlast, pd, pl);
            end
          end
          if (m_tvalid && m_tready) begin
            got_dat.push_back(m_tdata);
            got_last.push_back(m_tlast);
          end
          stalled = m_tvalid && !m_tready;
          pd = m_tdata;
          pl = m_tlast;
          @(posedge clk); #1;
          cyc++;
        end
      end
    join
    checks++;
    if (got_dat.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats expected 6", got_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < 6; i++) begin
      checks++;
      if (got_dat[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, got_dat[i], got_last[i], exp_d[i], exp_l[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    m_tready = 1'b0;
    send_beat(32'h31, 1'b0);
    send_beat(32'h32, 1'b1);
    send_beat(32'h51, 1'b0);
    send_beat(32'h52, 1'b0);
    rst      = 1'b1;
    en       = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h53;
    s_tlast  = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL mid_reset_tready: got %b expected 1", s_tready); end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    checks++;
    if (pkt_count !== 5'd0 || drop_count !== 16'd0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got pkt=%0d drop=%0d valid=%b expected 0/0/0", pkt_count, drop_count, m_tvalid);
    end
    @(posedge clk); #1;
    send_beat(32'h01, 1'b0);
    send_beat(32'h02, 1'b1);
    collect(3, 20, cyc);
    checks++;
    if (got_dat.size() != 2) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d beats expected 2", got_dat.size());
    end else begin
      checks++;
      if (got_dat[0] !== 32'h01 || got_last[0] !== 1'b0 || got_dat[1] !== 32'h02 || got_last[1] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_data: got %h/%b %h/%b expected 01/0 02/1", got_dat[0], got_last[0], got_dat[1], got_last[1]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_single_packet();
    test_no_tlast();
    test_overflow_drop();
    test_oversize();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_packet_buffer.md
AXIS_PACKET_BUFFER -- requirements
Module: axis_packet_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: tdata width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: buffer depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter DROP_CNT_WIDTH, default 16: width of the drop counter.
REQ-004 SHALL have ports: axis_aclk  in  1  single clock, all logic rising-edge; axis_areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: s_axis_enable in 1 ingress enable; s_axis_tdata in DATA_WIDTH; s_axis_tstrb in DATA_WIDTH/8; s_axis_tvalid in 1; s_axis_tlast in 1; s_axis_tready out 1.
REQ-006 SHALL have ports: m_axis_tready in 1; m_axis_tdata out DATA_WIDTH; m_axis_tstrb out DATA_WIDTH/8; m_axis_tvalid out 1; m_axis_tlast out 1.
REQ-007 SHALL have ports: pkt_count out ADDR_WIDTH+1, committed packets not yet loaded out; drop_count out DROP_CNT_WIDTH, saturating.

Function
REQ-008 SHALL be store-and-forward: no beat of a packet appears on m_axis before that packet's tlast beat is accepted.
REQ-009 SHALL drive s_axis_tready = s_axis_enable; beats accept on tvalid&&tready; enable low mid-packet only stalls.
REQ-010 SHALL store tdata, tstrb and tlast per word in a DEPTH-entry array.
REQ-011 SHALL keep ADDR_WIDTH+1-bit pointers: wr_commit, wr_cur (speculative), rd_ptr; all wrap modulo 2*DEPTH.
REQ-012 SHALL treat the array as full when wr_cur - rd_ptr == DEPTH.
REQ-013 SHALL run ingress FSM states RECV and DROP, RECV after reset.
REQ-014 RECV, beat accepted, not full: write at wr_cur, wr_cur+1; if tlast, wr_commit <= wr_cur+1 and pkt_count+1.
REQ-015 RECV, beat accepted, full, not tlast: discard, wr_cur <= wr_commit, go DROP.
REQ-016 RECV, beat accepted, full, tlast: discard, wr_cur <= wr_commit, drop_count+1, stay RECV.
REQ-017 DROP: discard accepted beats; on tlast drop_count+1, go RECV; wr_cur untouched.
REQ-018 SHALL drop any packet longer than DEPTH beats in full; no partial packet is ever emitted.
REQ-019 Egress SHALL use one output register; load mem[rd_ptr] when pkt_count != 0 and (!m_axis_tvalid || m_axis_tready); rd_ptr+1.
REQ-020 Loading a word with tlast=1 SHALL decrement pkt_count; simultaneous commit and decrement leaves it unchanged.
REQ-021 Latency: tlast accepted at edge E into empty buffer -> m_axis_tvalid high after edge E+1.
REQ-022 With m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tstrb/tlast SHALL hold stable.
REQ-023 Throughput SHALL be one beat per cycle each side, including back-to-back packets.
REQ-024 drop_count SHALL saturate at 2**DROP_CNT_WIDTH-1.

Reset
REQ-025 With axis_areset high at an edge: pointers 0, FSM RECV, pkt_count 0, drop_count 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tstrb 0.
REQ-026 Reset mid-packet SHALL discard all partial and stored packets; array contents need not clear.
REQ-027 s_axis_tready SHALL still follow s_axis_enable during reset; beats offered then are discarded.

Structure
REQ-028 Ingress FSM state encoding and the DEPTH/pointer-width helpers SHALL live in shared package axis_pkg.
REQ-029 The storage array SHALL be sub-module axis_buf_ram (1 write port, 1 synchronous-or-combinational read port, parametrised width/depth).

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=16)
REQ-030 4-beat packet 0x11,0x22,0x33,0x44, tstrb 0xF, m_tready=1 -> m_tvalid 1 edge after tlast accepted, same order, tlast on 0x44 only.
REQ-031 3 beats without tlast, m_tready=1 -> m_axis_tvalid stays 0 for 20 cycles; pkt_count 0.
REQ-032 m_tready=0; 10-beat packet A then 10-beat packet B -> A stored, B dropped, drop_count=1, pkt_count=1; m_tready=1 outputs A only.
REQ-033 20-beat packet then 2-beat packet 0xAA,0xBB -> drop_count=1; output exactly 0xAA,0xBB with tlast on 0xBB.
REQ-034 Two 3-beat packets back-to-back, m_tready pattern 1,0,1,0... -> all 6 beats in order, data stable during stalls, no loss.
REQ-035 axis_areset pulsed after beat 2 of 5-beat packet, then 2-beat packet 0x01,0x02 -> only 0x01,0x02 emitted; counters 0 after reset.
